mdu_hilo: RTL
=============

Name: mdu_hilo

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers; sits in EX, directly downstream of the register file.
- Consumes the two register-file read operands (rs/rt values after forwarding) for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Supplies HI/LO to the EX result mux for MFHI/MFLO.
- Busy stalls the front of the pipeline until the result is valid.

Parameters:
- XLEN, 32, operand/HI/LO width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  in  1  pipeline clock; everything is updated on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- Start  in  1  issue request for the operation on Op; sampled each cycle.
- Op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (treated as no-op).
- OpA  in  XLEN  rs value (multiplicand/dividend, MTHI/MTLO source).
- OpB  in  XLEN  rt value (multiplier/divisor).
- Cancel  in  1  pipeline flush; aborts any in-flight operation.
- Busy  out  1  operation in flight; the hazard unit stalls ID/EX and MFHI/MFLO while it is high.
- Done  out  1  one-cycle pulse, asserted the cycle after HI/LO take a mult/div result.
- HiData  out  XLEN  current HI register.
- LoData  out  XLEN  current LO register.

Behaviour:
- Reset (rst=1 at an edge): HI=0, LO=0, Busy=0, Done=0, FSM=IDLE, counter=0. Reset mid-operation aborts it and HI/LO are still cleared.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - Start && !Cancel with Op in {MULT, MULTU, DIV, DIVU}: latch operands (absolute values plus sign flags for the signed ops), counter=0, go to CALC.
  - MTHI: HI<=OpA at that edge; stay IDLE; Busy stays 0.
  - MTLO: LO<=OpA at that edge; stay IDLE; Busy stays 0.
  - Reserved Op: no effect.
- CALC:
  - Radix-2 shift-add multiply or restoring divide, one bit per cycle, XLEN cycles.
  - Counter reaching XLEN-1 goes to FIX.
- FIX:
  - Apply sign correction, write HI/LO at the exit edge, go to IDLE; Done=1 the following cycle.
- Busy=1 in CALC and FIX. Latency: Start accepted at edge N, Busy high cycles N+1..N+33, HI/LO valid and Done=1 in cycle N+34.
- Start while Busy=1 is ignored; the issuer must hold Start until Busy=0.
- Cancel=1 in CALC/FIX: go to IDLE at the next edge, HI/LO unchanged, no Done.
- Cancel=1 in IDLE: Start ignored that cycle, including MTHI/MTLO.
- Multiply: {HI,LO} = full 64-bit product. MULT is signed two's complement; MULTU is unsigned.
- Divide:
  - LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
  - Divisor 0: LO=32'hFFFFFFFF, HI=OpA (both DIV and DIVU).
  - DIV 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0.
- HiData/LoData are driven straight from the registers, with no bypass of an in-flight result.

Optional Feature:
- Macro MDU_DIV_EN.
- Defined: DIV/DIVU are implemented as above.
- Undefined:
  - Divider datapath is omitted. DIV/DIVU are accepted, produce no Busy, leave HI/LO unchanged, and give no Done (same as a reserved Op).
  - Multiply, MTHI/MTLO are unaffected.

Test Plan:
- Reset then idle: HI=0, LO=0, Busy=0, Done=0. Then MTHI 32'h12345678 and MTLO 32'h9ABCDEF0 on consecutive cycles -> registers updated the next cycle, Busy never 1.
- MULT 32'hFFFFFFFE x 32'h00000003 -> Busy high 33 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA, Done pulse 1 cycle. MULTU with the same operands -> HI=32'h00000002, LO=32'hFFFFFFFA.
- DIV -7/2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. DIVU 100/7 -> LO=14, HI=2. DIV 32'h80000000 / -1 -> LO=32'h80000000, HI=0.
- DIVU 5/0 -> LO=32'hFFFFFFFF, HI=5. With MDU_DIV_EN undefined, same stimulus -> HI/LO unchanged, Busy=0.
- Start a MULT, Cancel at CALC cycle 10 -> Busy=0 next cycle, HI/LO keep prior values, no Done. A second Start during Busy is ignored.
- rst=1 at CALC cycle 20 -> next cycle HI=LO=0, Busy=0. An immediate new MULT 3x4 -> LO=12, HI=0.

Source files
------------

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit owning the architectural HI/LO pair.
//
// Multiply is radix-2 shift-add and divide is restoring. Both handle one bit
// per cycle, so an operation takes XLEN CALC cycles plus one FIX cycle. FIX
// applies the sign correction and writes HI/LO.
//
// Ports:
//   clk     pipeline clock (rising edge)
//   rst     synchronous active-high reset; clears HI/LO and aborts any op
//   Start   issue request for Op (ignored while Busy or while Cancel is high)
//   Op      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   OpA     rs value: multiplicand / dividend / MTHI-MTLO source
//   OpB     rt value: multiplier / divisor
//   Cancel  pipeline flush; aborts an in-flight operation without writing HI/LO
//   Busy    high in CALC and FIX
//   Done    one-cycle pulse in the cycle after HI/LO take a mult/div result
//   HiData  HI register
//   LoData  LO register
//
// Configuration: define MDU_DIV_EN to build the divider. Without it, DIV/DIVU
// behave like reserved ops.
module mdu_hilo #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Start,
  input  logic [2:0]      Op,
  input  logic [XLEN-1:0] OpA,
  input  logic [XLEN-1:0] OpB,
  input  logic            Cancel,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] HiData,
  output logic [XLEN-1:0] LoData
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  // Upper half holds the partial product or remainder. Lower half holds the
  // multiplier or the dividend, which the quotient bits replace as they shift in.
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     b_q;        // multiplicand magnitude or divisor magnitude
  logic                neg_res_q;  // product / quotient must be negated
  logic [XLEN-1:0]     hi_q, lo_q;
  logic                done_q;
`ifdef MDU_DIV_EN
  logic                is_div_q;
  logic                neg_rem_q;  // remainder takes the dividend's sign
`endif

  // Operand decode and magnitude extraction at issue time.
  logic            op_mul, op_div, op_signed, neg_a, neg_b;
  logic [XLEN-1:0] abs_a, abs_b;

  assign op_mul = (Op == OP_MULT) || (Op == OP_MULTU);
`ifdef MDU_DIV_EN
  assign op_div = (Op == OP_DIV) || (Op == OP_DIVU);
`else
  assign op_div = 1'b0;
`endif
  assign op_signed = (Op == OP_MULT) || (Op == OP_DIV);
  assign neg_a     = op_signed & OpA[XLEN-1];
  assign neg_b     = op_signed & OpB[XLEN-1];
  assign abs_a     = neg_a ? -OpA : OpA;
  assign abs_b     = neg_b ? -OpB : OpB;

  // One iteration of the active algorithm, plus the final sign-corrected results.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, prod_fix;
  logic [XLEN-1:0]   hi_fix, lo_fix;
`ifdef MDU_DIV_EN
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   quo, rem;
`endif

  // NOTE: every signal assigned in this block gets a value on every path
  // (defaults first), so no latches are inferred.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    prod_fix = neg_res_q ? -acc_q : acc_q;
    acc_d    = mul_next;
    hi_fix   = prod_fix[2*XLEN-1:XLEN];
    lo_fix   = prod_fix[XLEN-1:0];
`ifdef MDU_DIV_EN
    // The shifted remainder is at most 2*divisor-1, so it needs XLEN+1 bits.
    // Bit XLEN of the difference is the borrow.
    div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    if (!div_trial[XLEN])
      div_next = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else
      div_next = {acc_q[2*XLEN-2:0], 1'b0};
    quo = acc_q[XLEN-1:0];
    rem = acc_q[2*XLEN-1:XLEN];
    if (is_div_q) begin
      acc_d = div_next;
      // A zero divisor yields all-ones quotient and remainder |A|. Skipping the
      // quotient negation and restoring A's sign on the remainder gives LO=~0, HI=OpA.
      lo_fix = (neg_res_q && (b_q != '0)) ? -quo : quo;
      hi_fix = neg_rem_q ? -rem : rem;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      neg_res_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
`ifdef MDU_DIV_EN
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start && !Cancel) begin
            if (op_mul || op_div) begin
              acc_q     <= {{XLEN{1'b0}}, (op_div ? abs_a : abs_b)};
              b_q       <= op_div ? abs_b : abs_a;
              neg_res_q <= neg_a ^ neg_b;
              cnt_q     <= '0;
              state_q   <= CALC;
`ifdef MDU_DIV_EN
              is_div_q  <= op_div;
              neg_rem_q <= neg_a;
`endif
            end else if (Op == OP_MTHI) begin
              hi_q <= OpA;
            end else if (Op == OP_MTLO) begin
              lo_q <= OpA;
            end
          end
        end
        CALC: begin
          if (Cancel) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) state_q <= FIX;
          end
        end
        FIX: begin
          state_q <= IDLE;
          if (!Cancel) begin
            hi_q   <= hi_fix;
            lo_q   <= lo_fix;
            done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy   = (state_q != IDLE);
  assign Done   = done_q;
  assign HiData = hi_q;
  assign LoData = lo_q;

endmodule
